note_sprite_reader: RTL and testbench

//   Read-side client of the 20x30 note sprite ROMs (1-cycle registered read, addr = row*20 + col).

---
 rtl/note_sprite_reader.sv | 196 +++++++++++++++++++
 tb/tb_note_sprite_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sprite_reader.sv
// Note sprite ROM read client: per-pixel hit test over a note position table, ROM address
// generation and 2-cycle raster alignment. Define NOTE_SHADOW_EN for a vblank-committed shadow table.
module note_sprite_reader #(
  parameter int  NUM_NOTES = 8,
  parameter int  SPR_W     = 20,
  parameter int  SPR_H     = 30,
  parameter int  H_ACTIVE  = 640,
  parameter int  V_ACTIVE  = 480,
  localparam int SLOT_W    = $clog2(NUM_NOTES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              video_on,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic              wr_show,
  input  logic              clear_all,
  output logic [9:0]        rom_addr,
  input  logic              rom_pixel,
  output logic              note_pixel,
  output logic [SLOT_W-1:0] note_slot
);

  logic                 wr_fire;
  logic [NUM_NOTES-1:0] live_valid_q, live_valid_d;
  logic [9:0]           live_x_q [NUM_NOTES];
  logic [9:0]           live_x_d [NUM_NOTES];
  logic [9:0]           live_y_q [NUM_NOTES];
  logic [9:0]           live_y_d [NUM_NOTES];

  assign wr_fire = wr_valid && wr_ready;

`ifdef NOTE_SHADOW_EN
  logic                 commit;
  logic [NUM_NOTES-1:0] shad_valid_q, shad_valid_d;
  logic [9:0]           shad_x_q [NUM_NOTES];
  logic [9:0]           shad_x_d [NUM_NOTES];
  logic [9:0]           shad_y_q [NUM_NOTES];
  logic [9:0]           shad_y_d [NUM_NOTES];

  // Commit happens on the first pixel of vertical blank; writes are held off for that one cycle.
  assign commit   = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
  assign wr_ready = !commit;

  always_comb begin
    shad_valid_d = shad_valid_q;
    shad_x_d     = shad_x_q;
    shad_y_d     = shad_y_q;
    if (clear_all) begin
      shad_valid_d = '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        if (wr_slot == SLOT_W'(i)) begin
          shad_valid_d[i] = wr_show;
          shad_x_d[i]     = wr_x;
          shad_y_d[i]     = wr_y;
        end
      end
    end
  end

  always_comb begin
    live_valid_d = live_valid_q;
    live_x_d     = live_x_q;
    live_y_d     = live_y_q;
    if (commit) begin
      live_valid_d = shad_valid_q;
      live_x_d     = shad_x_q;
      live_y_d     = shad_y_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shad_valid_q <= '0;
    else          shad_valid_q <= shad_valid_d;
  end

  always_ff @(posedge clk) begin
    shad_x_q <= shad_x_d;
    shad_y_q <= shad_y_d;
  end
`else
  assign wr_ready = 1'b1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    live_valid_d = live_valid_q;
    live_x_d     = live_x_q;
    live_y_d     = live_y_q;
    if (clear_all) begin
      live_valid_d = '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        if (wr_slot == SLOT_W'(i)) begin
          live_valid_d[i] = wr_show;
          live_x_d[i]     = wr_x;
          live_y_d[i]     = wr_y;
        end
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live_valid_q <= '0;
    else          live_valid_q <= live_valid_d;
  end

  // NOTE: coordinate storage is deliberately not reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    live_x_q <= live_x_d;
    live_y_q <= live_y_d;
  end

  // Stage 0: hit test in 11 bits so a sprite near column 1023 never wraps to column 0.
  logic [NUM_NOTES-1:0] slot_hit;
  logic                 hit_any;
  logic [SLOT_W-1:0]    win_idx;
  logic [9:0]           win_dx, win_dy;
  logic                 pix_on;

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      slot_hit[i] = live_valid_q[i]
                 && ({1'b0, hcount} >= {1'b0, live_x_q[i]})
                 && ({1'b0, hcount} <  {1'b0, live_x_q[i]} + 11'(SPR_W))
                 && ({1'b0, vcount} >= {1'b0, live_y_q[i]})
                 && ({1'b0, vcount} <  {1'b0, live_y_q[i]} + 11'(SPR_H));
    end
  end

  // Scan from the top slot down so the lowest hitting index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    win_idx = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_any = 1'b1;
        win_idx = SLOT_W'(i);
        win_dx  = hcount - live_x_q[i];
        win_dy  = vcount - live_y_q[i];
      end
    end
  end

  // Redundant with video_on for a compliant timing generator; keeps stray overscan dark.
  assign pix_on = video_on && (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));

  logic [9:0]        rom_addr_q, rom_addr_d;
  logic              hit_d1_q, hit_d1_d;
  logic [SLOT_W-1:0] slot_d1_q, slot_d1_d;
  logic              video_on_d1_q, video_on_d1_d;
  logic              note_pixel_q, note_pixel_d;
  logic [SLOT_W-1:0] note_slot_q, note_slot_d;

  always_comb begin
    rom_addr_d    = hit_any ? (win_dy * 10'(SPR_W) + win_dx) : 10'd0;
    hit_d1_d      = hit_any;
    slot_d1_d     = win_idx;
    video_on_d1_d = pix_on;
    note_pixel_d  = rom_pixel & hit_d1_q & video_on_d1_q;
    note_slot_d   = slot_d1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q    <= '0;
      hit_d1_q      <= 1'b0;
      slot_d1_q     <= '0;
      video_on_d1_q <= 1'b0;
      note_pixel_q  <= 1'b0;
      note_slot_q   <= '0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      hit_d1_q      <= hit_d1_d;
      slot_d1_q     <= slot_d1_d;
      video_on_d1_q <= video_on_d1_d;
      note_pixel_q  <= note_pixel_d;
      note_slot_q   <= note_slot_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign note_pixel = note_pixel_q;
  assign note_slot  = note_slot_q;

endmodule

// File: tb/tb_note_sprite_reader.sv
// Randomized bench for note_sprite_reader against an integer-arithmetic model of the note table.
// Honours NOTE_SHADOW_EN the same way the design does.
module tb_note_sprite_reader;

  localparam int N     = 8;
  localparam int SPR_W = 20;
  localparam int SPR_H = 30;
`ifdef NOTE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hcount, vcount;
  logic       video_on;
  logic       wr_valid, wr_ready;
  logic [2:0] wr_slot;
  logic [9:0] wr_x, wr_y;
  logic       wr_show, clear_all;
  logic [9:0] rom_addr;
  logic       rom_pixel;
  logic       note_pixel;
  logic [2:0] note_slot;

  bit rom_mem [1024];
  assign rom_pixel = rom_mem[rom_addr];

  note_sprite_reader dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y),
    .wr_show(wr_show), .clear_all(clear_all), .rom_addr(rom_addr), .rom_pixel(rom_pixel),
    .note_pixel(note_pixel), .note_slot(note_slot)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference table: live copy drives the hit test, shadow copy only matters with NOTE_SHADOW_EN.
  bit mv [N];
  int mx [N];
  int my [N];
  bit sv [N];
  int sx [N];
  int sy [N];

  typedef struct {
    bit hit;
    int slot;
    int addr;
    bit von;
  } exp_t;

  exp_t s1, s2;

  function automatic exp_t ref_lookup(input int h, input int v, input bit von);
    exp_t e;
    e = '{hit: 1'b0, slot: 0, addr: 0, von: von};
    for (int i = 0; i < N; i++) begin
      if (mv[i] && h >= mx[i] && h < mx[i] + SPR_W && v >= my[i] && v < my[i] + SPR_H) begin
        e.hit  = 1'b1;
        e.slot = i;
        e.addr = (v - my[i]) * SPR_W + (h - mx[i]);
        break;
      end
    end
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; sv[i] = 1'b0;
      mx[i] = 0; my[i] = 0; sx[i] = 0; sy[i] = 0;
    end
    s1 = '{hit: 1'b0, slot: 0, addr: 0, von: 1'b0};
    s2 = s1;
  endfunction

  function automatic void model_edge(input int h, input int v, input bit fire, input int slot,
                                     input int x, input int y, input bit show, input bit clr);
    if (SHADOW) begin
      if (h == 0 && v == 480) begin
        mv = sv; mx = sx; my = sy;
      end
      if (clr) begin
        for (int i = 0; i < N; i++) sv[i] = 1'b0;
      end else if (fire) begin
        sv[slot] = show; sx[slot] = x; sy[slot] = y;
      end
    end else begin
      if (clr) begin
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
      end else if (fire) begin
        mv[slot] = show; mx[slot] = x; my[slot] = y;
      end
    end
  endfunction

  task automatic check_outputs();
    check("rom_addr", int'(rom_addr), s1.addr);
    check("note_pixel", int'(note_pixel), int'(s2.hit & s2.von & rom_mem[s2.addr]));
    check("note_slot", int'(note_slot), s2.slot);
  endtask

  // One pixel clock: check the pipeline, drive the next raster/write inputs, advance the model.
  task automatic step(input int h, input int v, input bit wv = 1'b0, input int slot = 0,
                      input int x = 0, input int y = 0, input bit show = 1'b0,
                      input bit clr = 1'b0);
    exp_t e;
    bit   rdy;
    @(negedge clk);
    check_outputs();
    hcount    = 10'(h);
    vcount    = 10'(v);
    video_on  = (h < 640) && (v < 480);
    wr_valid  = wv;
    wr_slot   = 3'(slot);
    wr_x      = 10'(x);
    wr_y      = 10'(y);
    wr_show   = show;
    clear_all = clr;
    rdy = !(SHADOW && h == 0 && v == 480);
    #1;
    check("wr_ready", int'(wr_ready), int'(rdy));
    e = ref_lookup(h, v, video_on);
    @(posedge clk);
    s2 = s1;
    s1 = e;
    model_edge(h, v, wv && rdy, slot, x, y, show, clr);
  endtask

  task automatic commit_frame();
    step(0, 480);
  endtask

  initial begin
    int h, v, k;
    model_reset();
    reset_n = 1'b0;
    hcount = '0; vcount = '0; video_on = 1'b0;
    wr_valid = 1'b0; wr_slot = '0; wr_x = '0; wr_y = '0; wr_show = 1'b0; clear_all = 1'b0;
    rom_mem[305] = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_note_pixel", int'(note_pixel), 0);
    check("reset_note_slot", int'(note_slot), 0);
    check("reset_wr_ready", int'(wr_ready), 1);
    reset_n = 1'b1;

    // Single sprite: corners, just-outside column, and the ROM hit at address 305.
    step(0, 0, 1'b1, 0, 100, 50, 1'b1);
    commit_frame();
    step(100, 50);
    step(119, 79);
    step(120, 50);
    step(105, 65);
    step(106, 65);

    // Asynchronous reset mid-frame while note_pixel for (105,65) is being shown.
    #2 reset_n = 1'b0;
    #1;
    check("midreset_note_pixel", int'(note_pixel), 0);
    check("midreset_rom_addr", int'(rom_addr), 0);
    check("midreset_note_slot", int'(note_slot), 0);
    check("midreset_wr_ready", int'(wr_ready), 1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(105, 65);
    step(100, 50);

    // Overlap: slot 0 owns the shared region.
    step(0, 0, 1'b1, 0, 100, 50, 1'b1);
    step(0, 1, 1'b1, 1, 110, 60, 1'b1);
    commit_frame();
    step(112, 62);
    step(125, 70);
    step(105, 65);

    // Right-edge sprite never wraps onto column 5.
    step(0, 2, 1'b1, 2, 1015, 200, 1'b1);
    commit_frame();
    step(5, 200);
    step(1016, 201);
    step(3, 200);

    // clear_all beats a same-cycle write.
    step(0, 3, 1'b1, 3, 300, 300, 1'b1, 1'b1);
    commit_frame();
    step(305, 305);
    step(112, 62);

    // Mid-frame write; with a shadow table it stays hidden until the commit pixel.
    step(0, 100, 1'b1, 0, 200, 100, 1'b1);
    step(205, 105);
    step(219, 129);
    commit_frame();
    step(205, 105);

    // Write held across the commit pixel completes on the following cycle.
    step(0, 480, 1'b1, 4, 400, 150, 1'b1);
    step(1, 480, 1'b1, 4, 400, 150, 1'b1);
    commit_frame();
    step(410, 160);
    step(2, 2);
    step(3, 3);

    for (int i = 0; i < 1024; i++) rom_mem[i] = 1'($urandom_range(0, 1));

    for (int n = 0; n < 1500; n++) begin
      k = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 31) == 0) begin
        h = 0; v = 480;
      end else if ($urandom_range(0, 3) == 0) begin
        h = int'($urandom_range(0, 799));
        v = int'($urandom_range(0, 524));
      end else begin
        h = (mx[k] + int'($urandom_range(0, 25)) - 3) & 1023;
        v = (my[k] + int'($urandom_range(0, 35)) - 3) & 1023;
      end
      step(h, v,
           $urandom_range(0, 4) == 0,
           int'($urandom_range(0, N - 1)),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 1023))
                                        : int'($urandom_range(0, 639)),
           int'($urandom_range(0, 479)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    end

    step(0, 0);
    step(0, 0);
    step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
